// File: rtl/hwag_pkg.sv
// Shared types and constants for the HWAG crank-wheel synchronisation path.
package hwag_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FIRST,
      MEASURE,
      HUNT,
      SYNC
   } hwag_sync_state_t;

   // A period at least (prev << HWAG_GAP_SHIFT) is a missing-tooth gap.
   localparam int unsigned HWAG_GAP_SHIFT = 1;

endpackage

// File: rtl/hwag_period_timer.sv
// Saturating edge-to-edge timer: clears on request, reports the captured
// period (timer+1, saturated) and flags when the idle count reaches STALL.
module hwag_period_timer #(
   parameter int              TW    = 24,
   parameter logic [TW-1:0]   STALL = 24'hFF_FFFF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run_i,
   input  logic          clr_i,
   output logic [TW-1:0] period_o,
   output logic          timeout_o
);

   localparam logic [TW-1:0] TMAX = '1;

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      if (!run_i || clr_i) begin
         cnt_d = '0;
      end else if (cnt_q != TMAX) begin
         cnt_d = cnt_q + TW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The edge at this cycle closes the interval, so it counts one more cycle.
   assign period_o  = (cnt_q == TMAX) ? TMAX : cnt_q + TW'(1);
   assign timeout_o = run_i && (cnt_q == STALL);

endmodule

// File: rtl/hwag_sync_ctrl.sv
// Crank-wheel sync FSM: hunts for the missing-tooth gap, tracks tooth position
// and re-verifies the gap every revolution, with stall detection.
module hwag_sync_ctrl
   import hwag_pkg::*;
#(
   parameter int            TW    = 24,
   parameter int            CW    = 8,
   parameter int            TEETH = 58,
   parameter logic [TW-1:0] STALL = 24'hFF_FFFF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          edge_in,
   output logic          cap_ena,
   output logic          sync,
   output logic [CW-1:0] tooth_cnt,
   output logic [TW-1:0] period,
   output logic          gap_pulse,
   output logic          sync_lost,
   output logic          stall
);

   hwag_sync_state_t state_q, state_d;
   logic             cap_ena_q, cap_ena_d;
   logic             sync_q, sync_d;
   logic [CW-1:0]    tooth_q, tooth_d;
   logic [TW-1:0]    period_q, period_d;
   logic [TW-1:0]    prev_q, prev_d;
   logic             gap_q, gap_d;
   logic             lost_q, lost_d;
   logic             stall_q, stall_d;

   logic [TW-1:0]    cap_period;
   logic             timeout;
   logic             is_gap;
   logic             sync_err;

   hwag_period_timer #(
      .TW    (TW),
      .STALL (STALL)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .run_i     (state_q != IDLE),
      .clr_i     (edge_in || timeout || !start),
      .period_o  (cap_period),
      .timeout_o (timeout)
   );

   // Extra MSB keeps the doubled reference from wrapping.
   assign is_gap = {1'b0, cap_period} >= ({1'b0, prev_q} << HWAG_GAP_SHIFT);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      state_d  = state_q;
      sync_d   = sync_q;
      tooth_d  = tooth_q;
      period_d = period_q;
      prev_d   = prev_q;
      gap_d    = 1'b0;
      lost_d   = 1'b0;
      stall_d  = stall_q;
      sync_err = 1'b0;

      if (!start) begin
         state_d  = IDLE;
         sync_d   = 1'b0;
         tooth_d  = '0;
         period_d = '0;
         prev_d   = '0;
         stall_d  = 1'b0;
      end else if (state_q == IDLE) begin
         state_d = FIRST;
      end else if (edge_in) begin
         case (state_q)
            FIRST: state_d = MEASURE;
            MEASURE: begin
               period_d = cap_period;
               prev_d   = cap_period;
               state_d  = HUNT;
            end
            HUNT: begin
               period_d = cap_period;
               if (is_gap) begin
                  state_d = SYNC;
                  sync_d  = 1'b1;
                  tooth_d = '0;
                  gap_d   = 1'b1;
               end else begin
                  prev_d = cap_period;
               end
            end
            SYNC: begin
               period_d = cap_period;
               if (tooth_q == CW'(TEETH - 1)) begin
                  if (is_gap) begin
                     tooth_d = '0;
                     gap_d   = 1'b1;
                  end else begin
                     sync_err = 1'b1;
                  end
               end else if (is_gap) begin
                  sync_err = 1'b1;
               end else begin
                  tooth_d = tooth_q + CW'(1);
                  prev_d  = cap_period;
               end
            end
            default: state_d = IDLE;
         endcase

         if (sync_err) begin
            lost_d  = 1'b1;
            sync_d  = 1'b0;
            tooth_d = '0;
            prev_d  = cap_period;
            state_d = HUNT;
         end
      end else if (timeout) begin
         lost_d  = sync_q;
         stall_d = 1'b1;
         sync_d  = 1'b0;
         tooth_d = '0;
         state_d = FIRST;
      end

      cap_ena_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state_q   <= IDLE;
         cap_ena_q <= 1'b0;
         sync_q    <= 1'b0;
         tooth_q   <= '0;
         period_q  <= '0;
         prev_q    <= '0;
         gap_q     <= 1'b0;
         lost_q    <= 1'b0;
         stall_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cap_ena_q <= cap_ena_d;
         sync_q    <= sync_d;
         tooth_q   <= tooth_d;
         period_q  <= period_d;
         prev_q    <= prev_d;
         gap_q     <= gap_d;
         lost_q    <= lost_d;
         stall_q   <= stall_d;
      end
   end

   assign cap_ena   = cap_ena_q;
   assign sync      = sync_q;
   assign tooth_cnt = tooth_q;
   assign period    = period_q;
   assign gap_pulse = gap_q;
   assign sync_lost = lost_q;
   assign stall     = stall_q;

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Scoreboard bench for hwag_sync_ctrl: a cycle-level wheel model predicts each
// edge/stall response, a negedge monitor compares what the DUT presents.
module tb_hwag_sync_ctrl;

   localparam int            TW    = 24;
   localparam int            CW    = 8;
   localparam int            TEETH = 6;
   localparam logic [TW-1:0] STALL = 24'd1000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          edge_in = 1'b0;
   logic          cap_ena, sync, gap_pulse, sync_lost, stall;
   logic [CW-1:0] tooth_cnt;
   logic [TW-1:0] period;

   always #5 clk = ~clk;

   hwag_sync_ctrl #(.TW(TW), .CW(CW), .TEETH(TEETH), .STALL(STALL)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .edge_in   (edge_in),
      .cap_ena   (cap_ena),
      .sync      (sync),
      .tooth_cnt (tooth_cnt),
      .period    (period),
      .gap_pulse (gap_pulse),
      .sync_lost (sync_lost),
      .stall     (stall)
   );

   typedef struct {
      bit gap;
      bit lost;
      bit locked;
      int tooth;
      int per;
      bit stl;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Wheel model: tracks what has been learned about the wheel so far.
   bit m_run, m_armed, m_ref_ok, m_locked, m_stall;
   int m_ref, m_pos, m_per, m_elapsed;

   function automatic void model_step(bit s, bit r, bit e);
      int   p;
      bit   g, gp, lost;
      exp_t it;
      gp = 0;
      lost = 0;
      if (r || !s) begin
         m_run = 0; m_armed = 0; m_ref_ok = 0; m_locked = 0; m_stall = 0;
         m_ref = 0; m_pos = 0; m_per = 0; m_elapsed = 0;
         return;
      end
      if (!m_run) begin
         m_run = 1;
         m_elapsed = 0;
         return;
      end
      if (e) begin
         p = m_elapsed + 1;
         m_elapsed = 0;
         if (!m_armed) begin
            m_armed = 1;
         end else begin
            m_per = p;
            g = (p >= 2 * m_ref);
            if (!m_ref_ok) begin
               m_ref = p;
               m_ref_ok = 1;
            end else if (!m_locked) begin
               if (g) begin m_locked = 1; m_pos = 0; gp = 1; end
               else m_ref = p;
            end else if (g == (m_pos == TEETH - 1)) begin
               if (g) begin m_pos = 0; gp = 1; end
               else begin m_pos++; m_ref = p; end
            end else begin
               lost = 1; m_locked = 0; m_pos = 0; m_ref = p;
            end
         end
         it = '{gp, lost, m_locked, m_pos, m_per, m_stall};
         sb.push_back(it);
      end else if (m_elapsed == int'(STALL)) begin
         lost = m_locked;
         m_stall = 1; m_armed = 0; m_ref_ok = 0; m_locked = 0; m_pos = 0;
         m_elapsed = 0;
         it = '{0, lost, 0, 0, m_per, 1};
         sb.push_back(it);
      end else begin
         m_elapsed++;
      end
   endfunction

   task automatic cycle(input bit e);
      edge_in = e;
      model_step(start, rst, e);
      @(negedge clk);
      edge_in = 1'b0;
   endtask

   task automatic period_edge(input int p);
      repeat (p - 1) cycle(1'b0);
      cycle(1'b1);
   endtask

   // Monitor: an edge response or a fresh stall is what the DUT presents.
   logic edge_smp = 1'b0;
   logic stall_prev = 1'b0;
   always @(posedge clk) edge_smp <= edge_in;

   exp_t mon_it;
   bit   mon_trig;
   always @(negedge clk) begin
      mon_trig = edge_smp || (stall && !stall_prev);
      stall_prev = stall;
      if (mon_trig) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_it = sb.pop_front();
            check("gap_pulse", 32'(gap_pulse), 32'(mon_it.gap));
            check("sync_lost", 32'(sync_lost), 32'(mon_it.lost));
            check("sync", 32'(sync), 32'(mon_it.locked));
            check("tooth_cnt", 32'(tooth_cnt), 32'(mon_it.tooth));
            check("period", 32'(period), 32'(mon_it.per));
            check("stall", 32'(stall), 32'(mon_it.stl));
         end
      end else if (gap_pulse || sync_lost) begin
         check("spurious_pulse", {30'd0, gap_pulse, sync_lost}, 32'd0);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      // Reset state
      repeat (3) cycle(1'b0);
      check("rst_cap_ena", 32'(cap_ena), 32'd0);
      check("rst_sync", 32'(sync), 32'd0);
      check("rst_tooth", 32'(tooth_cnt), 32'd0);
      check("rst_period", 32'(period), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_pulses", {30'd0, gap_pulse, sync_lost}, 32'd0);

      // 1. Acquire sync
      rst = 1'b0;
      start = 1'b1;
      cycle(1'b0);
      check("cap_ena_rise", 32'(cap_ena), 32'd1);
      cycle(1'b1);
      repeat (4) period_edge(100);
      check("hunt_no_sync", 32'(sync), 32'd0);
      period_edge(300);
      check("acq_sync", 32'(sync), 32'd1);
      check("acq_gap_pulse", 32'(gap_pulse), 32'd1);
      check("acq_tooth", 32'(tooth_cnt), 32'd0);
      check("acq_period", 32'(period), 32'd300);

      // 2. Verified revolutions
      repeat (3) begin
         repeat (5) period_edge(100);
         check("rev_tooth5", 32'(tooth_cnt), 32'd5);
         period_edge(300);
         check("rev_gap", {30'd0, gap_pulse, sync}, 32'd3);
      end

      // 3. Early gap at tooth 2
      repeat (2) period_edge(100);
      check("early_tooth2", 32'(tooth_cnt), 32'd2);
      period_edge(300);
      check("early_lost", {30'd0, sync_lost, sync}, 32'd2);
      cycle(1'b0);
      check("early_lost_width", 32'(sync_lost), 32'd0);
      period_edge(100);
      period_edge(300);
      check("early_resync", 32'(sync), 32'd1);

      // 4. Missing gap
      repeat (5) period_edge(100);
      check("miss_tooth5", 32'(tooth_cnt), 32'd5);
      period_edge(100);
      check("miss_lost", {30'd0, sync_lost, sync}, 32'd2);
      period_edge(300);
      check("miss_resync", 32'(sync), 32'd1);

      // 5. Stall
      repeat (1005) cycle(1'b0);
      check("stall_set", 32'(stall), 32'd1);
      check("stall_sync", 32'(sync), 32'd0);
      check("stall_first_cap", 32'(cap_ena), 32'd1);
      start = 1'b0;
      cycle(1'b0);
      check("stall_clear", 32'(stall), 32'd0);
      check("stop_cap_ena", 32'(cap_ena), 32'd0);

      // 6A. Abort mid-HUNT
      start = 1'b1;
      cycle(1'b0);
      cycle(1'b1);
      period_edge(100);
      period_edge(100);
      start = 1'b0;
      cycle(1'b0);
      check("abort_cap_ena", 32'(cap_ena), 32'd0);
      check("abort_no_lost", 32'(sync_lost), 32'd0);
      check("abort_period", 32'(period), 32'd0);

      // 6B. Reset while in SYNC
      start = 1'b1;
      cycle(1'b0);
      cycle(1'b1);
      period_edge(100);
      period_edge(100);
      period_edge(300);
      check("pre_rst_sync", 32'(sync), 32'd1);
      rst = 1'b1;
      cycle(1'b0);
      check("rst_sync_outs", {22'd0, cap_ena, sync, gap_pulse, sync_lost, stall, 5'd0},
            32'd0);
      check("rst_sync_tooth_period", 32'(tooth_cnt) | 32'(period), 32'd0);
      rst = 1'b0;

      // Back-to-back edges
      cycle(1'b0);
      cycle(1'b1);
      cycle(1'b1);
      cycle(1'b1);
      period_edge(2);
      check("b2b_sync", 32'(sync), 32'd1);
      check("b2b_period", 32'(period), 32'd2);

      // Randomized wheel
      for (int i = 0; i < 150; i++) begin
         if ((m_locked && m_pos == TEETH - 1 && $urandom_range(0, 99) < 85) ||
             $urandom_range(0, 99) < 20) begin
            p = 2 * m_ref + int'($urandom_range(0, 10));
         end else begin
            p = int'($urandom_range(1, 150));
         end
         if (p < 1) p = 1;
         if (p > 400) p = 400;
         period_edge(p);
      end

      repeat (3) cycle(1'b0);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
